pq_port_arbiter: RTL and testbench
==================================

PQ_PORT_ARBITER -- requirements
Module: pq_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one max-priority queue (range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, node key width; it matches the queue.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1, idle cycles after each queue command (minimum 1).
REQ-004 SHALL have port i_CLK  input  1  single clock, rising edge.
REQ-005 SHALL have port i_RSTn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_push_valid  input  NUM_REQ  per-requester enqueue request.
REQ-007 SHALL have port i_push_data  input  NUM_REQ*DATA_WIDTH  enqueue key; requester r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port o_push_ready  output  NUM_REQ  enqueue accepted this cycle.
REQ-009 SHALL have port i_pop_valid  input  NUM_REQ  per-requester dequeue request.
REQ-010 SHALL have port o_pop_ready  output  NUM_REQ  dequeue accepted this cycle.
REQ-011 SHALL have port o_rsp_valid  output  NUM_REQ  one-cycle pulse marking the dequeue result.
REQ-012 SHALL have port o_rsp_data  output  DATA_WIDTH  dequeued key, shared by all requesters.
REQ-013 SHALL have port o_q_wrt  output  1  queue enqueue strobe.
REQ-014 SHALL have port o_q_read  output  1  queue dequeue strobe.
REQ-015 SHALL have port o_q_data  output  DATA_WIDTH  queue enqueue key.
REQ-016 SHALL have port i_q_full  input  1  queue full flag.
REQ-017 SHALL have port i_q_empty  input  1  queue empty flag.
REQ-018 SHALL have port i_q_data  input  DATA_WIDTH  current queue head (maximum key).
REQ-019 SHALL have port o_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-020 SHALL implement FSM with two states: IDLE and SETTLE. IDLE -> SETTLE on any grant. SETTLE -> IDLE after SETTLE_CYCLES cycles, counted by an internal counter.
REQ-021 SHALL grant no request while in SETTLE; all ready outputs, o_q_wrt and o_q_read are 0 in SETTLE.
REQ-022 SHALL treat requester r as eligible in IDLE when (i_push_valid[r] && !i_q_full) || (i_pop_valid[r] && !i_q_empty).
REQ-023 SHALL pick exactly one eligible requester per IDLE cycle, round-robin, searching upward from pointer rr_ptr with wrap modulo NUM_REQ.
REQ-024 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ on each grant; rr_ptr is unchanged otherwise.
REQ-025 SHALL drive o_q_wrt, o_q_read, o_q_data, o_push_ready and o_pop_ready combinationally in the grant cycle; the queue samples them at that cycle's rising edge.
REQ-026 SHALL handle a granted requester with push only: o_q_wrt=1, o_q_data=its key, o_push_ready[r]=1.
REQ-027 SHALL handle a granted requester with pop only: o_q_read=1, o_pop_ready[r]=1.
REQ-028 SHALL handle a granted requester with both push and pop, queue neither full nor empty, as a replace: o_q_wrt=1, o_q_read=1, both readies high.
REQ-029 SHALL grant push only when the requester has both valid and the queue is empty; the pop stays pending.
REQ-030 SHALL grant pop only when the requester has both valid and the queue is full; a full-queue replace is never issued, so no key is lost.
REQ-031 SHALL register i_q_data at the pop-grant edge, then assert o_rsp_valid[r] for exactly the next cycle with o_rsp_data equal to that registered value (latency 1).
REQ-032 SHALL hold o_rsp_data at its last value when o_rsp_valid is all-zero.
REQ-033 SHALL place no constraint on valid deassertion before ready; a dropped request is simply not granted.

Reset
REQ-034 SHALL, on i_RSTn low (asynchronous, any state including SETTLE or mid-response), force FSM=IDLE, rr_ptr=0, settle counter=0, o_rsp_valid=0, o_rsp_data=0 and o_busy=0.
REQ-035 SHALL drop any response pending at reset; combinational strobes and readies SHALL be 0 while i_RSTn is low.

Configuration
REQ-036 SHALL add, when macro PQ_ARB_OCC_EN is defined, output port o_level [$clog2(NUM_REQ*64+1)-1:0] holding occupancy: +1 on push, -1 on pop, unchanged on replace, reset 0.
REQ-037 SHALL, when PQ_ARB_OCC_EN is undefined, omit o_level and its counter entirely; all other behaviour is identical.

Verification
REQ-038 SHALL cover: reset, then requester 2 pushes 0x0005 -> o_q_wrt=1 and o_push_ready=4'b0100 the same cycle; o_busy=1 for 1 cycle; rr_ptr=3.
REQ-039 SHALL cover: all four requesters push simultaneously with rr_ptr=0 -> grants in order 0,1,2,3, each grant separated by SETTLE_CYCLES idle cycles.
REQ-040 SHALL cover: queue head 0x0009, requester 1 pops -> o_rsp_valid=4'b0010 and o_rsp_data=0x0009 one cycle after the grant.
REQ-041 SHALL cover: i_q_full=1 while requester 0 has both push and pop valid -> pop only is granted; o_push_ready[0]=0.
REQ-042 SHALL cover: i_q_empty=1 and only pop requests pending -> no grant, o_q_read never asserted.
REQ-043 SHALL cover: i_RSTn pulsed low during the response cycle -> o_rsp_valid=0 immediately; the next grant starts from requester 0.

Source files
------------

// File: rtl/pq_port_arbiter.sv
// pq_port_arbiter
//   Round-robin arbiter letting NUM_REQ requesters share one max-priority
//   queue. Each IDLE cycle, one eligible requester is granted a push, a pop,
//   or a replace (push+pop). The grant is followed by SETTLE_CYCLES idle
//   cycles so the queue can reorder. A pop result is returned one cycle after
//   the grant on the shared o_rsp_data bus, tagged by o_rsp_valid.
//
// Ports
//   i_CLK, i_RSTn        clock (rising edge), asynchronous active-low reset
//   i_push_valid/_data   per-requester enqueue request and key
//   o_push_ready         enqueue accepted (grant cycle, combinational)
//   i_pop_valid          per-requester dequeue request
//   o_pop_ready          dequeue accepted (grant cycle, combinational)
//   o_rsp_valid/_data    one-cycle dequeue result pulse and shared key
//   o_q_wrt/_read/_data  queue strobes and enqueue key
//   i_q_full/_empty/_data queue status and current head (maximum key)
//   o_busy               high whenever the FSM is not IDLE
//   o_level              occupancy counter (only with PQ_ARB_OCC_EN)
//
// Configuration
//   PQ_ARB_OCC_EN        define to add the o_level occupancy output

module pq_port_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic [NUM_REQ-1:0]            i_push_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_push_data,
  output logic [NUM_REQ-1:0]            o_push_ready,
  input  logic [NUM_REQ-1:0]            i_pop_valid,
  output logic [NUM_REQ-1:0]            o_pop_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_q_wrt,
  output logic                          o_q_read,
  output logic [DATA_WIDTH-1:0]         o_q_data,
  input  logic                          i_q_full,
  input  logic                          i_q_empty,
  input  logic [DATA_WIDTH-1:0]         i_q_data,
`ifdef PQ_ARB_OCC_EN
  output logic [$clog2(NUM_REQ*64+1)-1:0] o_level,
`endif
  output logic                          o_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   settle_cnt;

  logic [NUM_REQ-1:0] elig;
  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_idx;
  logic               do_push;
  logic               do_pop;

  // Eligibility is suppressed outside IDLE and while reset is held, which
  // forces every strobe and ready low in those conditions.
  always_comb begin
    elig = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      elig[r] = ((i_push_valid[r] && !i_q_full) || (i_pop_valid[r] && !i_q_empty))
                && (state == IDLE) && i_RSTn;
    end
  end

  // Round-robin search upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
  end

  // Push is blocked by full and pop by empty, so a requester with both valid
  // degrades to push-only on empty and pop-only on full; a replace therefore
  // only happens when the queue is neither full nor empty.
  always_comb begin
    do_push      = gnt_found && i_push_valid[gnt_idx] && !i_q_full;
    do_pop       = gnt_found && i_pop_valid[gnt_idx] && !i_q_empty;
    o_push_ready = '0;
    o_pop_ready  = '0;
    if (do_push) o_push_ready[gnt_idx] = 1'b1;
    if (do_pop)  o_pop_ready[gnt_idx]  = 1'b1;
    o_q_wrt  = do_push;
    o_q_read = do_pop;
    o_q_data = do_push ? i_push_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      settle_cnt  <= '0;
      o_busy      <= 1'b0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
    end else begin
      o_rsp_valid <= o_pop_ready;
      if (do_pop) o_rsp_data <= i_q_data;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            state      <= SETTLE;
            o_busy     <= 1'b1;
            settle_cnt <= '0;
            rr_ptr     <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef PQ_ARB_OCC_EN
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_level <= '0;
    end else if (do_push && !do_pop) begin
      o_level <= o_level + 1'b1;
    end else if (do_pop && !do_push) begin
      o_level <= o_level - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pq_port_arbiter.sv
module tb_pq_port_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  push_valid;
  logic [NR*DW-1:0] push_data;
  logic [NR-1:0]  push_ready;
  logic [NR-1:0]  pop_valid;
  logic [NR-1:0]  pop_ready;
  logic [NR-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic           q_wrt, q_read;
  logic [DW-1:0]  q_wdata;
  logic           q_full, q_empty;
  logic [DW-1:0]  q_head;
  logic           busy;
`ifdef PQ_ARB_OCC_EN
  logic [$clog2(NR*64+1)-1:0] level;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pq_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(1)) dut (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_push_valid(push_valid), .i_push_data(push_data), .o_push_ready(push_ready),
    .i_pop_valid(pop_valid), .o_pop_ready(pop_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_q_wrt(q_wrt), .o_q_read(q_read), .o_q_data(q_wdata),
    .i_q_full(q_full), .i_q_empty(q_empty), .i_q_data(q_head),
`ifdef PQ_ARB_OCC_EN
    .o_level(level),
`endif
    .o_busy(busy)
  );

  typedef struct {
    logic [3:0]  pv;
    logic [3:0]  ppv;
    logic [63:0] pd;
    logic        full;
    logic        empty;
    logic [15:0] head;
    logic [3:0]  e_push_rdy;
    logic [3:0]  e_pop_rdy;
    logic        e_wrt;
    logic        e_read;
    logic [15:0] e_qdata;
    logic [3:0]  e_rsp;
    logic [15:0] e_rsp_data;
    logic        e_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    push_valid = '0;
    pop_valid  = '0;
    push_data  = '0;
    q_full     = 1'b0;
    q_empty    = 1'b0;
    q_head     = '0;
  endtask

  function automatic vec_t mk(
    input logic [3:0] pv, input logic [3:0] ppv, input logic [63:0] pd,
    input logic full, input logic empty, input logic [15:0] head,
    input logic [3:0] epr, input logic [3:0] eopr, input logic ew, input logic er,
    input logic [15:0] eqd, input logic [3:0] ersp, input logic [15:0] ersd,
    input logic eb);
    vec_t v;
    v.pv = pv; v.ppv = ppv; v.pd = pd; v.full = full; v.empty = empty; v.head = head;
    v.e_push_rdy = epr; v.e_pop_rdy = eopr; v.e_wrt = ew; v.e_read = er;
    v.e_qdata = eqd; v.e_rsp = ersp; v.e_rsp_data = ersd; v.e_busy = eb;
    return v;
  endfunction

  initial begin
    // Expected values assume rr_ptr evolution 0->3->2->1->1->0->3->1->2->2->0.
    //              pv       ppv      pd                     full  empty head     push_rdy pop_rdy  wrt   read  qdata    rsp      rsp_data busy
    vecs[0] = mk(4'b0100, 4'b0000, 64'h0000_0005_0000_0000, 1'b0, 1'b0, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 16'h0005, 4'b0000, 16'h0000, 1'b1);
    vecs[1] = mk(4'b0000, 4'b0010, 64'h0,                   1'b0, 1'b0, 16'h0009, 4'b0000, 4'b0010, 1'b0, 1'b1, 16'h0000, 4'b0010, 16'h0009, 1'b1);
    vecs[2] = mk(4'b0001, 4'b0001, 64'h0000_0000_0000_00AA, 1'b1, 1'b0, 16'h0033, 4'b0000, 4'b0001, 1'b0, 1'b1, 16'h0000, 4'b0001, 16'h0033, 1'b1);
    vecs[3] = mk(4'b0000, 4'b1111, 64'h0,                   1'b0, 1'b1, 16'h0044, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 16'h0033, 1'b0);
    vecs[4] = mk(4'b1000, 4'b1000, 64'h0077_0000_0000_0000, 1'b0, 1'b1, 16'h0000, 4'b1000, 4'b0000, 1'b1, 1'b0, 16'h0077, 4'b0000, 16'h0033, 1'b1);
    vecs[5] = mk(4'b0100, 4'b0100, 64'h0000_0042_0000_0000, 1'b0, 1'b0, 16'h0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 16'h0042, 4'b0100, 16'h0100, 1'b1);
    vecs[6] = mk(4'b0011, 4'b0000, 64'h0000_0000_0022_0011, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'h0011, 4'b0000, 16'h0100, 1'b1);
    vecs[7] = mk(4'b0011, 4'b0000, 64'h0000_0000_0022_0011, 1'b0, 1'b0, 16'h0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 16'h0022, 4'b0000, 16'h0100, 1'b1);
    vecs[8] = mk(4'b1111, 4'b0000, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 16'h0100, 1'b0);
    vecs[9] = mk(4'b0010, 4'b1000, 64'h0000_0000_0055_0000, 1'b0, 1'b0, 16'h0ABC, 4'b0000, 4'b1000, 1'b0, 1'b1, 16'h0000, 4'b1000, 16'h0ABC, 1'b1);

    clear_inputs();
    rst_n = 1'b0;
    push_valid = 4'b0001;
    pop_valid  = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_q_wrt", 32'(q_wrt), 32'h0);
    chk("reset_q_read", 32'(q_read), 32'h0);
    chk("reset_push_ready", 32'(push_ready), 32'h0);
    clear_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      push_valid = vecs[i].pv;
      pop_valid  = vecs[i].ppv;
      push_data  = vecs[i].pd;
      q_full     = vecs[i].full;
      q_empty    = vecs[i].empty;
      q_head     = vecs[i].head;
      #1;
      chk($sformatf("v%0d_push_ready", i), 32'(push_ready), 32'(vecs[i].e_push_rdy));
      chk($sformatf("v%0d_pop_ready", i), 32'(pop_ready), 32'(vecs[i].e_pop_rdy));
      chk($sformatf("v%0d_q_wrt", i), 32'(q_wrt), 32'(vecs[i].e_wrt));
      chk($sformatf("v%0d_q_read", i), 32'(q_read), 32'(vecs[i].e_read));
      if (vecs[i].e_wrt)
        chk($sformatf("v%0d_q_data", i), 32'(q_wdata), 32'(vecs[i].e_qdata));
      @(posedge clk);
      #1;
      clear_inputs();
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rsp));
      chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_rsp_data));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy_after", i), 32'(busy), 32'h0);
      chk($sformatf("v%0d_rsp_after", i), 32'(rsp_valid), 32'h0);
    end

    // All four push together from rr_ptr=0: grants 0,1,2,3 with one idle cycle between.
    push_valid = 4'b1111;
    push_data  = 64'h0D0D_0C0C_0B0B_0A0A;
    for (int k = 0; k < 4; k++) begin
      logic [63:0] keys;
      keys = push_data;
      #1;
      chk($sformatf("rr%0d_push_ready", k), 32'(push_ready), 32'(4'b0001 << k));
      chk($sformatf("rr%0d_q_data", k), 32'(q_wdata), 32'(keys[k*16 +: 16]));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_settle_ready", k), 32'(push_ready), 32'h0);
      chk($sformatf("rr%0d_settle_wrt", k), 32'(q_wrt), 32'h0);
      chk($sformatf("rr%0d_settle_busy", k), 32'(busy), 32'h1);
      if (k == 3) clear_inputs();
      @(posedge clk);
      #0;
    end
    #1;
    chk("rr_done_busy", 32'(busy), 32'h0);

    // Reset during the response cycle: pulse dropped, next grant from requester 0.
    pop_valid = 4'b0010;
    q_head    = 16'h005A;
    #1;
    chk("rst_seq_pop_ready", 32'(pop_ready), 32'h2);
    @(posedge clk);
    #1;
    clear_inputs();
    chk("rst_seq_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("rst_seq_rsp_data", 32'(rsp_data), 32'h005A);
    rst_n = 1'b0;
    pop_valid = 4'b1111;
    #1;
    chk("rst_seq_rsp_cleared", 32'(rsp_valid), 32'h0);
    chk("rst_seq_rsp_data_cleared", 32'(rsp_data), 32'h0);
    chk("rst_seq_busy", 32'(busy), 32'h0);
    chk("rst_seq_q_read_low", 32'(q_read), 32'h0);
    @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b1;
    push_valid = 4'b0110;
    pop_valid  = 4'b0001;
    q_head     = 16'h0007;
    #1;
    chk("rst_seq_regrant_pop", 32'(pop_ready), 32'h1);
    chk("rst_seq_regrant_push", 32'(push_ready), 32'h0);
    @(posedge clk);
    #1;
    clear_inputs();
    chk("rst_seq_regrant_rsp", 32'(rsp_valid), 32'h1);
    chk("rst_seq_regrant_rsp_data", 32'(rsp_data), 32'h0007);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
